// File: rtl/vfd_frame_capture_pkg.sv
// Shared display definitions: default geometry, row-address and segment-pattern types
// used by the capture block and the video renderer.
package vfd_frame_capture_pkg;

   localparam int GRID_N_DEF  = 9;
   localparam int SEG_W_DEF   = 16;
   localparam int GRID_AW_DEF = 4;

   typedef logic [GRID_AW_DEF-1:0] row_addr_t;
   typedef logic [SEG_W_DEF-1:0]   seg_pattern_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/vfd_grid_encoder.sv
// One-hot to index encoder for the grid lines; flags exactly-one-hot and all-zero patterns.
module vfd_grid_encoder #(
   parameter int N  = 9,
   parameter int AW = 4
) (
   input  logic [N-1:0]  grid,
   output logic [AW-1:0] idx,
   output logic          one_hot,
   output logic          none
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grid[i]) idx = AW'(i);
      end
      none    = (grid == '0);
      one_hot = !none && ((grid & (grid - N'(1))) == '0);
   end

endmodule

// File: rtl/vfd_frame_capture.sv
// Samples the multiplexed grid/segment buses, commits glitch-free rows into a per-grid
// frame buffer with persistence decay, and serves the renderer through a registered read port.
module vfd_frame_capture
   import vfd_frame_capture_pkg::*;
#(
   parameter int GRID_N     = GRID_N_DEF,
   parameter int SEG_W      = SEG_W_DEF,
   parameter int STABLE_CYC = 3,
   parameter int DECAY_CYC  = 4096,
   parameter int GRID_AW    = GRID_AW_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_en,
   input  logic [GRID_N-1:0]  grid_i,
   input  logic [SEG_W-1:0]   seg_i,
   input  logic [GRID_AW-1:0] rd_addr,
   output logic [SEG_W-1:0]   rd_data,
   output logic               frame_tick,
   output logic [7:0]         glitch_cnt
);

   localparam int SW    = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
   localparam int AGE_W = $clog2(DECAY_CYC + 1);
   localparam logic [SW-1:0]    STAB_MAX  = SW'(STABLE_CYC - 1);
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(DECAY_CYC);

   logic [GRID_N+SEG_W-1:0] prev_sample;
   logic                    prev_valid;
   logic [SW-1:0]           stab_cnt;
   logic [SW-1:0]           stab_next;
   logic [GRID_AW-1:0]      last_idx;
   logic                    last_valid;
   logic [SEG_W-1:0]        rows [GRID_N];
   logic [AGE_W-1:0]        ages [GRID_N];

   logic [GRID_AW-1:0] enc_idx;
   logic               enc_one_hot;
   logic               enc_none;
   logic               same;
   logic               stab_sat;
   logic               stable;
   logic               first_stable;
   logic               commit;
   logic               glitch;
   logic               wrap;

   vfd_grid_encoder #(
      .N  (GRID_N),
      .AW (GRID_AW)
   ) u_grid_encoder (
      .grid    (grid_i),
      .idx     (enc_idx),
      .one_hot (enc_one_hot),
      .none    (enc_none)
   );

   // A sample with no predecessor since reset never counts as a repeat.
   always_comb begin
      same         = prev_valid && ({grid_i, seg_i} == prev_sample);
      stab_sat     = (stab_cnt == STAB_MAX);
      stab_next    = !same ? '0 : (stab_sat ? stab_cnt : stab_cnt + SW'(1));
      stable       = (stab_next == STAB_MAX);
      first_stable = stable && !(same && stab_sat);
      commit       = sample_en && stable && enc_one_hot;
      glitch       = sample_en && first_stable && !enc_one_hot && !enc_none;
      wrap         = last_valid && (enc_idx < last_idx);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_sample <= '0;
         prev_valid  <= 1'b0;
         stab_cnt    <= '0;
         last_idx    <= '0;
         last_valid  <= 1'b0;
         glitch_cnt  <= '0;
         frame_tick  <= 1'b0;
         rd_data     <= '0;
         for (int i = 0; i < GRID_N; i++) begin
            rows[i] <= '0;
            ages[i] <= AGE_LIMIT;
         end
      end else begin
         rd_data    <= (int'(rd_addr) < GRID_N) ? rows[rd_addr] : '0;
         frame_tick <= commit && wrap;
         if (sample_en) begin
            prev_sample <= {grid_i, seg_i};
            prev_valid  <= 1'b1;
            stab_cnt    <= stab_next;
            if (glitch) glitch_cnt <= sat_inc8(glitch_cnt);
            if (commit) begin
               last_idx   <= enc_idx;
               last_valid <= 1'b1;
            end
            // A commit to a row overrides both its aging and its expiry clear.
            for (int i = 0; i < GRID_N; i++) begin
               if (commit && (enc_idx == GRID_AW'(i))) begin
                  rows[i] <= seg_i;
                  ages[i] <= '0;
               end else if (ages[i] < AGE_LIMIT) begin
                  ages[i] <= ages[i] + AGE_W'(1);
                  if (ages[i] + AGE_W'(1) == AGE_LIMIT) rows[i] <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_vfd_frame_capture.sv
// Scoreboard bench for vfd_frame_capture: a run-length/timestamp reference model predicts
// every registered output, plus directed checks of capture, glitch, scan-wrap and decay cases.
module tb_vfd_frame_capture;
   import vfd_frame_capture_pkg::*;

   localparam int STABLE = 3;
   localparam int DECAY  = 16;
   localparam int GN     = 9;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         sample_en = 1'b0;
   logic [8:0]   grid_i = '0;
   seg_pattern_t seg_i = '0;
   row_addr_t    rd_addr = '0;
   logic [15:0]  rd_data;
   logic         frame_tick;
   logic [7:0]   glitch_cnt;

   typedef struct packed {
      logic [15:0] rd;
      logic        tick;
      logic [7:0]  glitch;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          ticks_seen = 0;

   logic        have_prev;
   logic [8:0]  prev_g;
   logic [15:0] prev_s;
   int          run;
   int          nsamp;
   int          last_k;
   int          m_glitch;
   logic [15:0] m_row [GN];
   int          commit_at [GN];

   always #5 clk = ~clk;

   vfd_frame_capture #(
      .GRID_N     (GN),
      .SEG_W      (16),
      .STABLE_CYC (STABLE),
      .DECAY_CYC  (DECAY),
      .GRID_AW    (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sample_en  (sample_en),
      .grid_i     (grid_i),
      .seg_i      (seg_i),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .frame_tick (frame_tick),
      .glitch_cnt (glitch_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      have_prev = 1'b0;
      prev_g    = '0;
      prev_s    = '0;
      run       = 0;
      nsamp     = 0;
      last_k    = -1;
      m_glitch  = 0;
      for (int i = 0; i < GN; i++) begin
         m_row[i]     = '0;
         commit_at[i] = -DECAY;
      end
   endtask

   // A row shows its last committed pattern until DECAY samples have passed since that commit.
   function automatic logic [15:0] rowVal(input int k);
      return ((nsamp - commit_at[k]) < DECAY) ? m_row[k] : 16'h0000;
   endfunction

   task automatic applyStimulus(input logic rst, input logic en, input logic [8:0] g,
                                input logic [15:0] s, input logic [3:0] a);
      exp_t e;
      exp_t got;
      int   k;
      int   pop;
      logic same;
      reset     = rst;
      sample_en = en;
      grid_i    = g;
      seg_i     = s;
      rd_addr   = a;
      e         = '0;
      if (rst) begin
         modelReset();
      end else begin
         e.rd = (int'(a) < GN) ? rowVal(int'(a)) : 16'h0000;
         if (en) begin
            nsamp++;
            same      = have_prev && (g == prev_g) && (s == prev_s);
            run       = same ? run + 1 : 1;
            have_prev = 1'b1;
            prev_g    = g;
            prev_s    = s;
            pop       = $countones(g);
            if (pop == 1 && run >= STABLE) begin
               k = 0;
               for (int i = 0; i < GN; i++) if (g[i]) k = i;
               m_row[k]     = s;
               commit_at[k] = nsamp;
               if (last_k >= 0 && k < last_k) e.tick = 1'b1;
               last_k = k;
            end
            if (pop > 1 && run == STABLE && m_glitch < 255) m_glitch++;
         end
         e.glitch = 8'(m_glitch);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         got = sb.pop_front();
         checkOutput("rd_data", 32'(rd_data), 32'(got.rd));
         checkOutput("frame_tick", 32'(frame_tick), 32'(got.tick));
         checkOutput("glitch_cnt", 32'(glitch_cnt), 32'(got.glitch));
      end
      if (frame_tick === 1'b1) ticks_seen++;
   endtask

   task automatic sampleN(input logic [8:0] g, input logic [15:0] s, input int n, input logic [3:0] a);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b1, g, s, a);
         applyStimulus(1'b0, 1'b0, g, s, 4'($urandom_range(0, 15)));
      end
   endtask

   task automatic readCheck(input string tag, input logic [3:0] a, input logic [15:0] exp);
      applyStimulus(1'b0, 1'b0, grid_i, seg_i, a);
      checkOutput(tag, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      logic [8:0]  rg;
      logic [15:0] rs;
      modelReset();
      applyStimulus(1'b1, 1'b0, '0, '0, 4'd0);
      applyStimulus(1'b1, 1'b0, '0, '0, 4'd2);
      checkOutput("reset_glitch", 32'(glitch_cnt), 32'd0);

      // Basic capture of grid 2
      sampleN(9'h004, 16'hA5A5, 3, 4'd2);
      readCheck("row2_capture", 4'd2, 16'hA5A5);
      readCheck("row0_empty", 4'd0, 16'h0000);

      // Transient pattern must not be committed
      sampleN(9'h008, 16'hA5A5, 2, 4'd3);
      sampleN(9'h008, 16'h1234, 3, 4'd3);
      readCheck("row3_settled", 4'd3, 16'h1234);

      // Multi-hot glitch counting and saturation
      sampleN(9'h006, 16'h0F0F, 5, 4'd1);
      sampleN(9'h00C, 16'h0F0F, 3, 4'd1);
      checkOutput("glitch_two", 32'(glitch_cnt), 32'd2);
      for (int p = 0; p < 300; p++) sampleN((p % 2 == 0) ? 9'h006 : 9'h00C, 16'h0F0F, 3, 4'd1);
      checkOutput("glitch_sat", 32'(glitch_cnt), 32'd255);

      // Full scan with wrap
      applyStimulus(1'b1, 1'b0, '0, '0, 4'd0);
      ticks_seen = 0;
      for (int g = 0; g < GN; g++) sampleN(9'(1) << g, 16'h1000 + 16'(g), 3, 4'(g));
      checkOutput("scan_no_tick_first_pass", 32'(ticks_seen), 32'd0);
      sampleN(9'h001, 16'h2000, 3, 4'd0);
      checkOutput("scan_one_tick", 32'(ticks_seen), 32'd1);
      readCheck("row8_scan", 4'd8, 16'h1008);

      // Decay of row 5 and refresh just before expiry
      sampleN(9'h020, 16'hBEEF, 3, 4'd5);
      sampleN(9'h000, 16'h0000, 15, 4'd5);
      readCheck("row5_before_decay", 4'd5, 16'hBEEF);
      sampleN(9'h000, 16'h0000, 1, 4'd5);
      readCheck("row5_decayed", 4'd5, 16'h0000);
      sampleN(9'h020, 16'hCAFE, 3, 4'd5);
      sampleN(9'h000, 16'h0000, 12, 4'd5);
      sampleN(9'h020, 16'hCAFE, 3, 4'd5);
      sampleN(9'h000, 16'h0000, 4, 4'd5);
      readCheck("row5_refreshed", 4'd5, 16'hCAFE);

      // Reset mid-scan discards everything
      for (int g = 0; g < 5; g++) sampleN(9'(1) << g, 16'h3000 + 16'(g), 3, 4'(g));
      sampleN(9'h006, 16'h0001, 3, 4'd1);
      sampleN(9'h020, 16'h7777, 2, 4'd5);
      applyStimulus(1'b1, 1'b1, 9'h020, 16'h7777, 4'd0);
      checkOutput("rst_glitch", 32'(glitch_cnt), 32'd0);
      checkOutput("rst_tick", 32'(frame_tick), 32'd0);
      checkOutput("rst_rd", 32'(rd_data), 32'd0);
      for (int i = 0; i < GN; i++) readCheck("rst_row", 4'(i), 16'h0000);
      ticks_seen = 0;
      sampleN(9'h004, 16'h5555, 3, 4'd2);
      checkOutput("post_rst_no_tick", 32'(ticks_seen), 32'd0);
      readCheck("post_rst_row2", 4'd2, 16'h5555);

      // Out-of-range addresses read zero
      for (int a = GN; a < 16; a++) readCheck("oob_addr", 4'(a), 16'h0000);

      // Random traffic against the model
      rg = 9'h001;
      rs = 16'h0000;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0:       rg = 9'h000;
               3:       rg = 9'($urandom_range(1, 511));
               default: rg = 9'(1) << $urandom_range(0, 8);
            endcase
            rs = 16'($urandom);
         end
         applyStimulus(1'b0, $urandom_range(0, 3) != 0, rg, rs, 4'($urandom_range(0, 15)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vfd_frame_capture.md
Name: vfd_frame_capture

Overview:
- Sits downstream of the 4-bit microcontroller core's output ports.
- The firmware multiplexes the display: one grid line is driven active at a time, while the segment lines carry that grid's pattern.
- This block samples the grid/segment buses, rejects transition glitches, and builds a per-grid frame buffer with persistence decay.
- The video renderer reads the buffer through a registered read port.

Parameters:
- GRID_N, 9, number of grid lines (one frame row per grid).
- SEG_W, 16, number of segment lines.
- STABLE_CYC, 3, consecutive identical samples required before a commit (must be ≥1).
- DECAY_CYC, 4096, samples without refresh before a row blanks.
- GRID_AW, 4, row address width; must satisfy 2^GRID_AW ≥ GRID_N.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- sample_en, input, 1, sample strobe; the MCU instruction-rate enable.
- grid_i, input, GRID_N, grid lines from the MCU ports, active-high.
- seg_i, input, SEG_W, segment lines from the MCU ports, active-high.
- rd_addr, input, GRID_AW, renderer row select.
- rd_data, output, SEG_W, registered row contents.
- frame_tick, output, 1, single-cycle pulse at each scan wrap.
- glitch_cnt, output, 8, saturating count of stable multi-hot grid patterns.

Behaviour:
- Reset: synchronous, active-high; clock clk.
  - All rows clear to 0.
  - All ages set to DECAY_CYC, so every row starts expired.
  - Stability counter 0, last_idx invalid.
  - rd_data, frame_tick and glitch_cnt all 0.
  - Reset asserted mid-scan discards all capture state the same cycle.
- Sampling: all state except the read port advances only on cycles where sample_en=1.
  - On a sample, compare {grid_i, seg_i} with the previous sample.
  - Equal: stab_cnt increments, saturating at STABLE_CYC-1.
  - Different: stab_cnt clears to 0.
- Stable condition: stab_cnt == STABLE_CYC-1 after the update. With STABLE_CYC=1, every sample is stable.
- Commit: on a stable sample where grid_i is exactly one-hot at index k:
  - row[k] <= seg_i and age[k] <= 0.
  - Commits repeat on every later stable sample, which refreshes the age.
  - Latency: row visible in storage 1 clk after the STABLE_CYC-th identical sample.
- Zero grids active (blanking interval): no commit, no error; stab_cnt behaves normally.
- Multi-hot grid: no commit.
  - glitch_cnt increments once per stable period, only on the sample where stab_cnt first reaches STABLE_CYC-1.
  - glitch_cnt saturates at 255.
- Decay: on each sample, every non-committed row with age < DECAY_CYC increments its age.
  - When the age reaches DECAY_CYC, the row clears to 0 on that same cycle.
  - A commit to the same row on the same sample wins over both aging and clearing.
- frame_tick: asserted for one clk on a commit where last_idx is valid and k < last_idx (scan wrapped).
  - last_idx <= k on every commit.
  - Re-committing the same index does not tick.
  - No tick on the first commit after reset.
- Read port: every clk, rd_data <= row[rd_addr].
  - Latency 1 clk, independent of sample_en.
  - rd_addr ≥ GRID_N returns 0.
  - A read of a row being committed in the same cycle returns the old value.
- Age counters: width clog2(DECAY_CYC+1), no wrap.

Decomposition:
- Shared display package holds:
  - default GRID_N/SEG_W constants;
  - a row address typedef;
  - a segment-pattern typedef, shared with the renderer.
- One sub-module: vfd_grid_encoder.
  - Combinational one-hot → index.
  - Outputs: idx, one_hot (exactly one bit set), none (all zero).
  - Reused by the key-scan path later.
- Stability logic, aging array and read port stay in the top module.

Test Plan:
- Hold grid=9'h004, seg=16'hA5A5 for 3 samples → 1 clk later read addr 2 gives 16'hA5A5; addr 0 still gives 0.
- Change seg to 16'h1234 after 2 samples, then hold it 3 samples → only 16'h1234 is ever committed; the transient 16'hA5A5 never appears.
- Stable grid=9'h006 for 5 samples, then 9'h00C for 3 samples → no commit; glitch_cnt = 2 (one per stable period). Drive 300 such periods → glitch_cnt holds at 255.
- Scan sequence: grids 0,1,…,8, then 0, each stable for 3 samples → exactly one frame_tick, coincident with the grid-0 commit after grid 8; none on the first pass.
- Commit row 5, then blank grids (grid=0) for DECAY_CYC=16 samples → row 5 reads 0 after the 16th sample. Refreshing it at sample 15 instead keeps it intact.
- Assert reset for 1 clk mid-scan with rows populated → every row, rd_data, glitch_cnt and frame_tick read 0. The next commit produces no tick.
